// File: rtl/jrb8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jrb8_pkg
// Purpose  : Shared constants and types for the jrb8 SPI memory initiator.
// Revision : 1.0  initial release
// ============================================================================
package jrb8_pkg;

    // 23LC-style command opcodes
    localparam logic [7:0] SPI_OP_READ    = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE   = 8'h02;

    // Opcode + 16-bit address + data byte
    localparam int         SPI_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : jrb8_pkg
`default_nettype wire

// File: rtl/jrb8_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : jrb8_sck_gen
// Purpose  : SCK half-period counter and toggle. Produces single-cycle rise and
//            fall strobes that coincide with the clk edge on which SCK changes.
// Revision : 1.0  initial release
// ============================================================================
module jrb8_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] phase_q, phase_d;
    logic       sck_q,   sck_d;
    logic       w_wrap;

    assign w_wrap = (phase_q == 8'(CLK_DIV - 1));

    // Count out each half-period; SCK flips when the half-period expires.
    // While disabled the generator sits at phase 0 with SCK low, so every
    // frame starts with a full low phase.
    always_comb begin
        phase_d = phase_q;
        sck_d   = sck_q;
        if (!en_i) begin
            phase_d = 8'd0;
            sck_d   = 1'b0;
        end else if (w_wrap) begin
            phase_d = 8'd0;
            sck_d   = ~sck_q;
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    // Phase counter and SCK register
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 8'd0;
            sck_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sck_q   <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = en_i && w_wrap && !sck_q;
    assign fall_o = en_i && w_wrap &&  sck_q;

endmodule : jrb8_sck_gen
`default_nettype wire

// File: rtl/jrb8_spi_mem.sv
`default_nettype none
// ============================================================================
// Module   : jrb8_spi_mem
// Purpose  : Single-byte SPI mode-0 memory initiator (0x03 read / 0x02 write,
//            16-bit address) serving the jrb8 CPU bus. All outputs registered.
// Revision : 1.0  initial release
// ============================================================================
module jrb8_spi_mem
    import jrb8_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state_q,  state_d;
    logic [31:0] shift_q,  shift_d;
    logic [4:0]  bit_q,    bit_d;
    logic [7:0]  rx_q,     rx_d;
    logic [7:0]  rdata_q,  rdata_d;
    logic        we_q,     we_d;
    logic        ready_q,  ready_d;
    logic        busy_q,   busy_d;
    logic        cs_n_q,   cs_n_d;
    logic        mosi_q,   mosi_d;

    logic        w_rise;
    logic        w_fall;
    logic        w_sck;
    logic [31:0] w_frame;

    assign w_frame = {(we ? SPI_OP_WRITE : SPI_OP_READ), addr, (we ? wdata : 8'h00)};

    jrb8_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == SHIFT),
        .sck_o  (w_sck),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    // Next-state and output logic. MOSI is only updated together with a
    // falling SCK strobe (or at frame start), so it is stable while SCK is high.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (req) begin
                    state_d = SHIFT;
                    shift_d = w_frame;
                    we_d    = we;
                    bit_d   = 5'd0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = w_frame[31];
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    rx_d = {rx_q[6:0], spi_miso};
                end
                if (w_fall) begin
                    shift_d = shift_q << 1;
                    mosi_d  = shift_q[30];
                    if (bit_q == 5'(SPI_FRAME_BITS - 1)) begin
                        state_d = DONE;
                        bit_d   = 5'd0;
                        cs_n_d  = 1'b1;
                        ready_d = 1'b1;
                        mosi_d  = 1'b0;
                        if (!we_q) begin
                            rdata_d = rx_q;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= 32'd0;
            bit_q   <= 5'd0;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sck  = w_sck;
    assign spi_mosi = mosi_q;

endmodule : jrb8_spi_mem
`default_nettype wire
